// File: rtl/gmii_rx_frame_checker.sv
// gmii_rx_frame_checker: per-port GMII receive integrity stage.
// Passes every byte through with a fixed 2-cycle latency and checks each
// frame for preamble/SFD, FCS (CRC-32), runt, giant and rx_err. A failing
// frame gets err forced on its final output byte.
//
// Ports (GMII words are packed {err, dv, data[7:0]}):
//   clk                 port GMII clock
//   rst                 asynchronous active-high reset
//   i_gmii_rxd_in[9:0]  raw receive err/dv/data
//   o_gmii_rxd_out[9:0] same stream 2 cycles later, err marked on bad frames
//   o_frame_done        pulse with the final byte of a frame on the output
//   o_frame_bad         valid with o_frame_done: frame failed a check
//   o_bad_cause[3:0]    valid with o_frame_done: {giant, runt, fcs, hdr_or_err}
// Optional macro GMII_RX_FRAME_CHECKER_STATS_EN adds saturating counters
//   o_frames_good_cnt, o_frames_bad_cnt, o_fcs_err_cnt (CNT_WIDTH bits each).
module gmii_rx_frame_checker #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           i_gmii_rxd_in,
    output logic [9:0]           o_gmii_rxd_out,
    output logic                 o_frame_done,
    output logic                 o_frame_bad,
    output logic [3:0]           o_bad_cause
`ifdef GMII_RX_FRAME_CHECKER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] o_frames_good_cnt,
    output logic [CNT_WIDTH-1:0] o_frames_bad_cnt,
    output logic [CNT_WIDTH-1:0] o_fcs_err_cnt
`endif
);

    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_LEN + 1);
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_FRAME_LEN);
    localparam logic [31:0] CRC_POLY_REV = 32'hEDB88320;
    localparam logic [31:0] CRC_MAGIC    = 32'hC704DD7B;
    localparam logic [7:0]  PRE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE     = 8'hD5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_BODY,
        S_DISCARD
    } state_t;

    state_t           r_state;
    logic [9:0]       r_s1;
    logic [2:0]       r_pre_cnt;
    logic [31:0]      r_crc;
    logic [LEN_W-1:0] r_len;
    logic             r_err_acc;
    logic             r_resync;

    logic [7:0]       w_data;
    logic             w_dv;
    logic             w_err;
    logic             w_last;
    logic [31:0]      w_crc_next;
    logic [LEN_W-1:0] w_len_next;
    logic [3:0]       w_cause;
    logic             w_bad;

    // Reflected CRC-32, one data bit per step, LSB first.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] c,
                                               input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY_REV : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [31:0] f_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign w_data     = r_s1[7:0];
    assign w_dv       = r_s1[8];
    assign w_err      = r_s1[9];
    assign w_last     = w_dv & ~i_gmii_rxd_in[8];
    assign w_crc_next = f_crc_byte(r_crc, w_data);
    assign w_len_next = (r_len == LEN_SAT) ? r_len : r_len + 1'b1;

    // A frame that never got past the header is only a header error;
    // length and FCS are meaningful only once the SFD was seen.
    always_comb begin
        w_cause = 4'b0001;
        if (r_state == S_BODY) begin
            w_cause = {w_len_next > MAX_L,
                       w_len_next < MIN_L,
                       f_rev32(w_crc_next) != CRC_MAGIC,
                       r_err_acc | w_err};
        end
    end

    assign w_bad = |w_cause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1           <= '0;
            o_gmii_rxd_out <= '0;
            o_frame_done   <= 1'b0;
            o_frame_bad    <= 1'b0;
            o_bad_cause    <= '0;
            r_state        <= S_IDLE;
            r_pre_cnt      <= '0;
            r_crc          <= '1;
            r_len          <= '0;
            r_err_acc      <= 1'b0;
            // Stays set until an idle input is seen, so a frame already
            // in flight at reset release is discarded.
            r_resync       <= 1'b1;
        end else begin
            r_s1           <= i_gmii_rxd_in;
            r_resync       <= r_resync & i_gmii_rxd_in[8];
            o_gmii_rxd_out <= {w_err | (w_last & w_bad), r_s1[8:0]};
            o_frame_done   <= w_last;
            o_frame_bad    <= w_last & w_bad;
            o_bad_cause    <= w_last ? w_cause : 4'b0000;
            if (w_dv) begin
                r_err_acc <= r_err_acc | w_err;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_dv) begin
                        if (r_resync) begin
                            r_state <= S_DISCARD;
                        end else if (w_data == PRE_BYTE) begin
                            r_state   <= S_PRE;
                            r_pre_cnt <= 3'd1;
                        end else if (w_data == SFD_BYTE) begin
                            r_state <= S_BODY;
                            r_crc   <= '1;
                            r_len   <= '0;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end
                end
                S_PRE: begin
                    if (w_data == PRE_BYTE && r_pre_cnt != 3'd7) begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                    end else if (w_data == SFD_BYTE) begin
                        r_state <= S_BODY;
                        r_crc   <= '1;
                        r_len   <= '0;
                    end else begin
                        r_state <= S_DISCARD;
                    end
                end
                S_BODY: begin
                    r_crc <= w_crc_next;
                    r_len <= w_len_next;
                end
                default: begin
                end
            endcase
            if (w_last) begin
                r_state   <= S_IDLE;
                r_err_acc <= 1'b0;
                r_pre_cnt <= '0;
            end
        end
    end

`ifdef GMII_RX_FRAME_CHECKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frames_good_cnt <= '0;
            o_frames_bad_cnt  <= '0;
            o_fcs_err_cnt     <= '0;
        end else if (w_last) begin
            if (w_bad) begin
                if (~&o_frames_bad_cnt) begin
                    o_frames_bad_cnt <= o_frames_bad_cnt + 1'b1;
                end
                if (w_cause[1] && ~&o_fcs_err_cnt) begin
                    o_fcs_err_cnt <= o_fcs_err_cnt + 1'b1;
                end
            end else if (~&o_frames_good_cnt) begin
                o_frames_good_cnt <= o_frames_good_cnt + 1'b1;
            end
        end
    end
`else
    // Counter width only matters when statistics are built in.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Randomized self-checking bench for gmii_rx_frame_checker.
// Expected output stream is derived per frame from the frame rules.
module tb_gmii_rx_frame_checker;

    localparam int MINL = 64;
    localparam int MAXL = 1518;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic [9:0] dout;
    logic       done;
    logic       bad;
    logic [3:0] cause;
`ifdef GMII_RX_FRAME_CHECKER_STATS_EN
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic [31:0] fcs_cnt;
`endif

    always #5 clk = ~clk;

    gmii_rx_frame_checker #(
        .MIN_FRAME_LEN(MINL),
        .MAX_FRAME_LEN(MAXL),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_gmii_rxd_in(din),
        .o_gmii_rxd_out(dout),
        .o_frame_done(done),
        .o_frame_bad(bad),
        .o_bad_cause(cause)
`ifdef GMII_RX_FRAME_CHECKER_STATS_EN
        ,
        .o_frames_good_cnt(good_cnt),
        .o_frames_bad_cnt(bad_cnt),
        .o_fcs_err_cnt(fcs_cnt)
`endif
    );

    logic [9:0] w_q[$];
    bit         r_q[$];
    logic [9:0] e_out[$];
    bit         e_done[$];
    bit         e_bad[$];
    logic [3:0] e_cause[$];
    logic [3:0] dut_causes[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         model_dones = 0;
    int         cyc = 0;
    bit         running = 0;

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {1'b0, r[31:1]} ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] crc_reg(input logic [7:0] b[$],
                                            input int cnt);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < cnt; i++) c = crc_upd(c, b[i]);
        return c;
    endfunction

    // Cause bits from a whole frame: {giant, runt, fcs, hdr_or_err}.
    function automatic logic [3:0] frame_cause(input logic [7:0] b[$],
                                               input bit anyerr,
                                               input bit resync);
        int n;
        int k;
        int nb;
        int len;
        logic [7:0] body[$];
        bit fcs;
        logic [31:0] rx_fcs;
        n = b.size();
        k = 0;
        if (resync) return 4'b0001;
        while (k < n && b[k] == 8'h55) k++;
        if (k > 7 || k >= n - 1 || b[k] != 8'hD5) return 4'b0001;
        for (int x = k + 1; x < n; x++) body.push_back(b[x]);
        nb = body.size();
        len = (nb > MAXL + 1) ? MAXL + 1 : nb;
        if (nb >= 4) begin
            rx_fcs = {body[nb-1], body[nb-2], body[nb-3], body[nb-4]};
            fcs = (~crc_reg(body, nb - 4)) != rx_fcs;
        end else begin
            fcs = crc_reg(body, nb) != 32'hDEBB20E3;
        end
        return {len > MAXL, len < MINL, fcs, anyerr};
    endfunction

    task automatic push(input logic [7:0] d, input bit dv, input bit er,
                        input bit r);
        w_q.push_back({er, dv, d});
        r_q.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) push(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int npre, input int plen, input int flip,
                              input int erri, input int badpre,
                              input int rsti, input int rstn, input int gap);
        logic [7:0] pay[$];
        logic [7:0] fb[$];
        logic [31:0] c;
        int hdr;
        int bi;
        for (int k = 0; k < npre; k++)
            fb.push_back(k == badpre ? 8'h5D : 8'h55);
        fb.push_back(8'hD5);
        for (int k = 0; k < plen; k++) pay.push_back(8'($urandom));
        c = ~crc_reg(pay, plen);
        for (int k = 0; k < 4; k++) pay.push_back(c[8*k +: 8]);
        hdr = npre + 1;
        for (int k = 0; k < pay.size(); k++)
            fb.push_back(k == flip ? pay[k] ^ 8'h01 : pay[k]);
        for (int k = 0; k < fb.size(); k++) begin
            bi = k - hdr;
            push(fb[k], 1'b1, erri >= 0 && bi == erri,
                 rsti >= 0 && bi >= rsti && bi < rsti + rstn);
        end
        idle(gap);
    endtask

    function automatic bit win_ok(input int j);
        return j >= 2 && !r_q[j] && !r_q[j-1] && !r_q[j-2];
    endfunction

    task automatic build_model();
        int n;
        int i;
        int s;
        int e;
        int j;
        bit resync;
        bit anyerr;
        bit complete;
        logic [3:0] fc;
        logic [7:0] b[$];
        n = w_q.size();
        for (int k = 0; k < n; k++) begin
            e_out.push_back(win_ok(k) ? w_q[k-2] : 10'h000);
            e_done.push_back(1'b0);
            e_bad.push_back(1'b0);
            e_cause.push_back(4'b0000);
        end
        i = 0;
        while (i < n) begin
            if (r_q[i] || !w_q[i][8]) begin
                i++;
            end else begin
                s = i;
                resync = (s == 0) || r_q[s-1];
                anyerr = 1'b0;
                b.delete();
                while (i < n && !r_q[i] && w_q[i][8]) begin
                    b.push_back(w_q[i][7:0]);
                    anyerr |= w_q[i][9];
                    i++;
                end
                e = i - 1;
                complete = (i < n) && !r_q[i];
                fc = frame_cause(b, anyerr, resync);
                j = e + 2;
                if (complete && j < n && win_ok(j)) begin
                    e_out[j][9] = w_q[e][9] | (|fc);
                    e_done[j] = 1'b1;
                    e_bad[j] = |fc;
                    e_cause[j] = fc;
                    model_dones++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            vectors++;
            if (dout !== e_out[cyc] || done !== e_done[cyc] ||
                bad !== e_bad[cyc] || cause !== e_cause[cyc]) begin
                miscompares++;
                $display("FAIL cycle %0d: got out=%h done=%b bad=%b cause=%b, want out=%h done=%b bad=%b cause=%b",
                         cyc, dout, done, bad, cause, e_out[cyc],
                         e_done[cyc], e_bad[cyc], e_cause[cyc]);
            end
            if (done === 1'b1) dut_causes.push_back(cause);
        end
    end

    logic [3:0] pin[13];
    int kind;
    int npre;
    int plen;
    int flip;
    int erri;
    int badpre;
    int rsti;
    int rstn;
`ifdef GMII_RX_FRAME_CHECKER_STATS_EN
    int m_good;
    int m_bad;
    int m_fcs;
`endif

    initial begin
        rst = 1'b1;
        din = '0;
        pin = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001,
                4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                4'b0100};
        repeat (3) push(8'h00, 1'b0, 1'b0, 1'b1);
        idle(3);
        send_frame(7, 60, -1, -1, -1, -1, 0, 1);
        send_frame(7, 60, 10, -1, -1, -1, 0, 1);
        send_frame(7, 52, -1, -1, -1, -1, 0, 1);
        send_frame(7, 1515, -1, -1, -1, -1, 0, 1);
        send_frame(7, 60, -1, 20, -1, -1, 0, 1);
        send_frame(7, 60, -1, -1, 3, -1, 0, 1);
        send_frame(7, 60, -1, -1, -1, -1, 0, 1);
        send_frame(7, 60, -1, -1, -1, -1, 0, 1);
        push(8'h55, 1'b1, 1'b0, 1'b0);
        idle(1);
        send_frame(7, 60, -1, -1, -1, 30, 2, 1);
        send_frame(7, 60, -1, -1, -1, -1, 0, 1);
        send_frame(7, 1514, -1, -1, -1, -1, 0, 1);
        send_frame(7, 59, -1, -1, -1, -1, 0, 1);
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            npre = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 7;
            plen = $urandom_range(40, 110);
            flip = -1;
            erri = -1;
            badpre = -1;
            rsti = -1;
            rstn = 0;
            case (kind)
                0: flip = $urandom_range(0, plen + 3);
                1: erri = $urandom_range(0, plen + 3);
                2: if (npre > 0) badpre = $urandom_range(0, npre - 1);
                3: begin
                    rsti = $urandom_range(0, plen + 3);
                    rstn = $urandom_range(1, 3);
                end
                default: ;
            endcase
            if (kind == 4) begin
                push(8'($urandom), 1'b1, 1'b0, 1'b0);
                idle($urandom_range(1, 3));
            end else begin
                send_frame(npre, plen, flip, erri, badpre, rsti, rstn,
                           $urandom_range(1, 3));
            end
        end
        idle(4);
        build_model();
        for (int j = 0; j < w_q.size(); j++) begin
            @(posedge clk);
            #1;
            rst = r_q[j];
            din = w_q[j];
            cyc = j;
            running = 1'b1;
        end
        @(posedge clk);
        #1;
        running = 1'b0;
        for (int k = 0; k < 13; k++) begin
            vectors++;
            if (k >= dut_causes.size() || dut_causes[k] !== pin[k]) begin
                miscompares++;
                $display("FAIL pinned frame %0d cause: got %b, want %b", k,
                         (k < dut_causes.size()) ? dut_causes[k] : 4'bxxxx,
                         pin[k]);
            end
        end
        vectors++;
        if (dut_causes.size() != model_dones) begin
            miscompares++;
            $display("FAIL frame count: got %0d, want %0d",
                     dut_causes.size(), model_dones);
        end
`ifdef GMII_RX_FRAME_CHECKER_STATS_EN
        m_good = 0;
        m_bad = 0;
        m_fcs = 0;
        for (int k = 0; k < e_done.size(); k++) begin
            if (e_done[k] && !e_bad[k]) m_good++;
            if (e_done[k] && e_bad[k]) m_bad++;
            if (e_done[k] && e_cause[k][1]) m_fcs++;
        end
        vectors++;
        if (good_cnt != 32'(m_good) || bad_cnt != 32'(m_bad) ||
            fcs_cnt != 32'(m_fcs)) begin
            miscompares++;
            $display("FAIL stats: got %0d/%0d/%0d, want %0d/%0d/%0d",
                     good_cnt, bad_cnt, fcs_cnt, m_good, m_bad, m_fcs);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
